// File: rtl/seg7_monitor.sv
// 7-segment bus receiver: synchronises, debounces and decodes a segment pattern
// back to hex, flagging steps and illegal glyphs. Define SEG7_MON_STATS_EN for counters.
module seg7_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic [3:0] value_out,
   output logic       valid,
   output logic       invalid,
   output logic       changed,
   output logic       step_up,
   output logic       step_down
`ifdef SEG7_MON_STATS_EN
   ,
   output logic [7:0] err_cnt,
   output logic [7:0] jump_cnt
`endif
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {SETTLE, ACCEPT, HOLD} state_t;

   state_t        state;
   logic [6:0]    s1, s2, cand;
   logic [6:0]    raw;
   logic [CW-1:0] stab_cnt;
   logic          have_prev;
   logic          glyph_ok;
   logic [3:0]    glyph_val;
   logic          is_up, is_down;

   // Inversion sits after the synchroniser so both flops see the raw pin level.
   assign raw = ACTIVE_LOW ? ~s2 : s2;

   // NOTE: every output of a combinational block gets a default first; otherwise
   // an unlisted case would have to hold its old value and a latch is inferred.
   always_comb begin
      glyph_ok  = 1'b1;
      glyph_val = 4'h0;
      case (cand)
         7'h3F: glyph_val = 4'h0;
         7'h06: glyph_val = 4'h1;
         7'h5B: glyph_val = 4'h2;
         7'h4F: glyph_val = 4'h3;
         7'h66: glyph_val = 4'h4;
         7'h6D: glyph_val = 4'h5;
         7'h7D: glyph_val = 4'h6;
         7'h07: glyph_val = 4'h7;
         7'h7F: glyph_val = 4'h8;
         7'h6F: glyph_val = 4'h9;
         7'h77: glyph_val = 4'hA;
         7'h7C: glyph_val = 4'hB;
         7'h39: glyph_val = 4'hC;
         7'h5E: glyph_val = 4'hD;
         7'h79: glyph_val = 4'hE;
         7'h71: glyph_val = 4'hF;
         default: glyph_ok = 1'b0;
      endcase
   end

   // 4-bit arithmetic makes F->0 and 0->F count as single steps.
   assign is_up   = (glyph_val == 4'(value_out + 4'd1));
   assign is_down = (glyph_val == 4'(value_out - 4'd1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         cand      <= '0;
         stab_cnt  <= '0;
         have_prev <= 1'b0;
         state     <= SETTLE;
         value_out <= 4'h0;
         valid     <= 1'b0;
         invalid   <= 1'b0;
         changed   <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
`ifdef SEG7_MON_STATS_EN
         err_cnt   <= 8'd0;
         jump_cnt  <= 8'd0;
`endif
      end else begin
         s1        <= seg_in;
         s2        <= s1;
         changed   <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;

         if (raw != cand) begin
            // A new pattern always wins, even on the cycle an accept was due.
            cand     <= raw;
            stab_cnt <= CNT_ONE;
            state    <= SETTLE;
            valid    <= 1'b0;
            invalid  <= 1'b0;
         end else begin
            if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + CNT_ONE;

            case (state)
               SETTLE: begin
                  if (stab_cnt == CNT_MAX) begin
                     state <= ACCEPT;
                     if (glyph_ok) begin
                        value_out <= glyph_val;
                        valid     <= 1'b1;
                        invalid   <= 1'b0;
                        have_prev <= 1'b1;
                        changed   <= !have_prev || (glyph_val != value_out);
                        step_up   <= have_prev && is_up;
                        step_down <= have_prev && is_down;
`ifdef SEG7_MON_STATS_EN
                        if (have_prev && (glyph_val != value_out) && !is_up && !is_down &&
                            (jump_cnt != 8'hFF))
                           jump_cnt <= jump_cnt + 8'd1;
`endif
                     end else begin
                        valid   <= 1'b0;
                        invalid <= 1'b1;
`ifdef SEG7_MON_STATS_EN
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
                     end
                  end
               end
               ACCEPT:  state <= HOLD;
               HOLD:    state <= HOLD;
               default: state <= SETTLE;
            endcase
         end
      end
   end

endmodule
